// File: rtl/ddr_line_cache.sv
// Direct-mapped, write-back, write-allocate cache of 128-bit lines between a
// 32-bit CPU port and a single-outstanding DDR bridge.
module ddr_line_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_valid,
    input  logic [24:0]  cpu_addr,
    input  logic [31:0]  cpu_wdata,
    input  logic [3:0]   cpu_wstrb,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic [20:0]  mem_addr,
    output logic [127:0] mem_wdata,
    output logic         mem_wstrb,
    output logic         mem_valid,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);
    localparam int TAG_BITS = 21 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        IDLE, COMPARE, WB, WB_GAP, FILL, FILL_GAP, RESP
    } state_t;

    state_t state, state_next;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [1:0]            req_word;
    logic [31:0]           req_wdata;
    logic [3:0]            req_wstrb;

    logic [LINES-1:0]    line_valid;
    logic [LINES-1:0]    line_dirty;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [127:0]        data_mem [LINES];

    logic hit, accept, issue_wb, issue_fill, mem_done, fill_done, respond;

    logic [6:0]   word_lsb;
    logic [31:0]  strb_mask;
    logic [127:0] cur_line, line_mask, line_wdata, merged_line, shifted_line;

    // Byte offset bits select nothing inside a 32-bit word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit = line_valid[req_index] && (tag_mem[req_index] == req_tag);

    // Merged line serves both the write-hit update and the read word select.
    assign word_lsb     = {req_word, 5'd0};
    assign strb_mask    = {{8{req_wstrb[3]}}, {8{req_wstrb[2]}}, {8{req_wstrb[1]}}, {8{req_wstrb[0]}}};
    assign cur_line     = data_mem[req_index];
    assign line_mask    = {96'd0, strb_mask} << word_lsb;
    assign line_wdata   = {96'd0, req_wdata} << word_lsb;
    assign merged_line  = (cur_line & ~line_mask) | (line_wdata & line_mask);
    assign shifted_line = merged_line >> word_lsb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every signal assigned in this block gets a default first, so no path leaves one holding its old value (no latch).
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue_wb   = 1'b0;
        issue_fill = 1'b0;
        mem_done   = 1'b0;
        fill_done  = 1'b0;
        respond    = 1'b0;
        case (state)
            // cpu_ready high means the CPU still holds cpu_valid for the finished request.
            IDLE: if (cpu_valid && !cpu_ready) begin
                accept     = 1'b1;
                state_next = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    state_next = RESP;
                end else if (line_dirty[req_index]) begin
                    issue_wb   = 1'b1;
                    state_next = WB;
                end else begin
                    issue_fill = 1'b1;
                    state_next = FILL;
                end
            end
            WB: if (mem_ready) begin
                mem_done   = 1'b1;
                state_next = WB_GAP;
            end
            WB_GAP: if (!mem_ready) begin
                issue_fill = 1'b1;
                state_next = FILL;
            end
            FILL: if (mem_ready) begin
                mem_done   = 1'b1;
                fill_done  = 1'b1;
                state_next = FILL_GAP;
            end
            FILL_GAP: if (!mem_ready) state_next = COMPARE;
            RESP: begin
                respond    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_tag    <= '0;
            req_index  <= '0;
            req_word   <= '0;
            req_wdata  <= '0;
            req_wstrb  <= '0;
            line_valid <= '0;
            line_dirty <= '0;
            cpu_ready  <= 1'b0;
            cpu_rdata  <= '0;
            mem_valid  <= 1'b0;
            mem_wstrb  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            cpu_ready <= 1'b0;
            if (accept) begin
                req_tag   <= cpu_addr[24 -: TAG_BITS];
                req_index <= cpu_addr[4 +: INDEX_BITS];
                req_word  <= cpu_addr[3:2];
                req_wdata <= cpu_wdata;
                req_wstrb <= cpu_wstrb;
            end
            if (issue_wb) begin
                mem_valid <= 1'b1;
                mem_wstrb <= 1'b1;
                mem_addr  <= {tag_mem[req_index], req_index};
                mem_wdata <= cur_line;
            end
            if (issue_fill) begin
                mem_valid <= 1'b1;
                mem_wstrb <= 1'b0;
                mem_addr  <= {req_tag, req_index};
            end
            if (mem_done) mem_valid <= 1'b0;
            if (fill_done) begin
                line_valid[req_index] <= 1'b1;
                line_dirty[req_index] <= 1'b0;
            end
            if (respond) begin
                cpu_ready <= 1'b1;
                cpu_rdata <= shifted_line[31:0];
                if (|req_wstrb) line_dirty[req_index] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays carry no reset; line_valid gates every use of their contents.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_mem[req_index] <= mem_rdata;
            tag_mem[req_index]  <= req_tag;
        end else if (respond && |req_wstrb) begin
            data_mem[req_index] <= merged_line;
        end
    end
endmodule

// File: tb/tb_ddr_line_cache.sv
// Randomized bench for ddr_line_cache: flat-memory reference model, residency model
// for expected DDR traffic, and a behavioural bridge with variable latency and sticky ready.
module tb_ddr_line_cache;
    localparam int INDEX_BITS = 4;
    localparam int LINES      = 1 << INDEX_BITS;
    localparam int TAG_BITS   = 21 - INDEX_BITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_valid;
    logic [24:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_wstrb;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [20:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_wstrb;
    logic         mem_valid;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    always #5 clk = ~clk;

    ddr_line_cache #(.INDEX_BITS(INDEX_BITS)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_valid(mem_valid),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    typedef struct {
        logic [20:0]  addr;
        logic         write;
        logic [127:0] data;
    } mem_req_t;

    mem_req_t     req_log[$];
    mem_req_t     exp_log[$];
    logic [127:0] ddr  [logic [20:0]];
    logic [127:0] flat [logic [20:0]];
    int           bridge_lat  = 0;
    int           bridge_hold = 0;
    int           vectors     = 0;
    int           miscompares = 0;

    logic                m_valid [LINES];
    logic                m_dirty [LINES];
    logic [TAG_BITS-1:0] m_tag   [LINES];
    logic                exp_hit;
    logic [31:0]         exp_rdata;

    function automatic logic [127:0] ddr_init(input logic [20:0] a);
        logic [127:0] l;
        if (a == 21'h1) return 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        for (int w = 0; w < 4; w++) l[32*w +: 32] = {a, 3'(w), 8'hC5};
        return l;
    endfunction

    function automatic logic [127:0] ddr_read(input logic [20:0] a);
        return ddr.exists(a) ? ddr[a] : ddr_init(a);
    endfunction

    function automatic logic [127:0] flat_read(input logic [20:0] a);
        return flat.exists(a) ? flat[a] : ddr_init(a);
    endfunction

    // Bridge: logs each request, answers after bridge_lat cycles, keeps ready high bridge_hold extra cycles.
    initial begin
        int       wait_cnt;
        int       hold_cnt;
        bit       busy;
        mem_req_t cur;
        mem_ready = 1'b0;
        mem_rdata = '0;
        busy      = 1'b0;
        wait_cnt  = 0;
        hold_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_ready = 1'b0;
                busy      = 1'b0;
            end else begin
                if (mem_ready) begin
                    if (hold_cnt > 0) hold_cnt--;
                    else begin
                        mem_ready = 1'b0;
                        mem_rdata = {4{$urandom}};
                    end
                end else if (!busy && mem_valid) begin
                    busy      = 1'b1;
                    wait_cnt  = bridge_lat;
                    cur.addr  = mem_addr;
                    cur.write = mem_wstrb;
                    cur.data  = mem_wdata;
                    req_log.push_back(cur);
                end
                if (busy && !mem_ready) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        if (cur.write) ddr[cur.addr] = cur.data;
                        else           mem_rdata = ddr_read(cur.addr);
                        mem_ready = 1'b1;
                        busy      = 1'b0;
                        hold_cnt  = bridge_hold;
                    end
                end
            end
        end
    end

    // Bridge-side protocol monitor: no new request while ready is high, stable request fields.
    initial begin
        logic         pv, pr, pw;
        logic [20:0]  pa;
        logic [127:0] pd;
        pv = 1'b0; pr = 1'b0; pw = 1'b0; pa = '0; pd = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (mem_valid && !pv) begin
                    vectors++;
                    if (pr !== 1'b0) begin
                        miscompares++;
                        $display("FAIL mem_valid_rise: mem_valid rose while mem_ready was %b, required 0", pr);
                    end
                end
                if (mem_valid && pv) begin
                    vectors++;
                    if ({mem_addr, mem_wstrb, mem_wdata} !== {pa, pw, pd}) begin
                        miscompares++;
                        $display("FAIL mem_stable: addr %h wstrb %b changed from addr %h wstrb %b while mem_valid=1",
                                 mem_addr, mem_wstrb, pa, pw);
                    end
                end
            end
            pv = mem_valid; pr = mem_ready; pa = mem_addr; pw = mem_wstrb; pd = mem_wdata;
        end
    end

    function automatic bit log_matches();
        if (req_log.size() != exp_log.size()) return 1'b0;
        foreach (exp_log[i]) begin
            if (req_log[i].addr !== exp_log[i].addr || req_log[i].write !== exp_log[i].write) return 1'b0;
            if (exp_log[i].write && req_log[i].data !== exp_log[i].data) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        flat = ddr;
    endtask

    // Predicts traffic and read data from cache rules over a flat view of memory.
    task automatic model_access(input logic [24:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [20:0]         line;
        logic [20:0]         victim;
        logic [3:0]          idx;
        logic [TAG_BITS-1:0] tag;
        int                  w;
        logic [127:0]        l;
        mem_req_t            e;
        line = addr[24:4];
        idx  = addr[7:4];
        tag  = addr[24:8];
        w    = int'(addr[3:2]);
        exp_log.delete();
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        if (!exp_hit) begin
            if (m_valid[idx] && m_dirty[idx]) begin
                victim  = {m_tag[idx], idx};
                e.addr  = victim;
                e.write = 1'b1;
                e.data  = flat_read(victim);
                exp_log.push_back(e);
            end
            e.addr  = line;
            e.write = 1'b0;
            e.data  = '0;
            exp_log.push_back(e);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        l = flat_read(line);
        exp_rdata = l[32*w +: 32];
        if (wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) l[32*w + 8*b +: 8] = wdata[8*b +: 8];
            flat[line]   = l;
            m_dirty[idx] = 1'b1;
        end
    endtask

    // One CPU transaction; lat counts edges from the sampling edge to the edge raising cpu_ready.
    task automatic run_access(input logic [24:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                              output logic [31:0] rdata, output int lat, output bit ok, output bit pulse_ok);
        int cyc;
        model_access(addr, wdata, wstrb);
        req_log.delete();
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        ok = 1'b0; pulse_ok = 1'b0; cyc = 0; lat = -1; rdata = '0;
        while (!ok && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cpu_ready) begin
                ok    = 1'b1;
                rdata = cpu_rdata;
                lat   = cyc - 1;
            end
        end
        @(posedge clk);
        #1;
        pulse_ok  = ok && (cpu_ready === 1'b0);
        cpu_valid = 1'b0;
        cpu_addr  = 25'($urandom);
        cpu_wdata = $urandom;
        cpu_wstrb = 4'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (cpu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_ready: got %b want 0", cpu_ready); end
        vectors++;
        if (mem_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        vectors++;
        if (mem_wstrb !== 1'b0) begin miscompares++; $display("FAIL reset_mem_wstrb: got %b want 0", mem_wstrb); end
        vectors++;
        if (mem_addr !== 21'h0) begin miscompares++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        vectors++;
        if (cpu_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_cold_read();
        logic [31:0] got; int lat; bit ok, pulse_ok;
        run_access(25'h0000010, 32'h0, 4'h0, got, lat, ok, pulse_ok);
        vectors++;
        if (!ok || !pulse_ok) begin miscompares++; $display("FAIL cold_handshake: done %b single_pulse %b want 1 1", ok, pulse_ok); end
        vectors++;
        if (got !== exp_rdata) begin miscompares++; $display("FAIL cold_rdata: got %h want %h", got, exp_rdata); end
        vectors++;
        if (!log_matches()) begin miscompares++; $display("FAIL cold_traffic: got %0d bridge requests want %0d (FILL only)", req_log.size(), exp_log.size()); end
    endtask

    task automatic test_read_hit();
        logic [31:0] got; int lat; bit ok, pulse_ok;
        run_access(25'h0000014, 32'h0, 4'h0, got, lat, ok, pulse_ok);
        vectors++;
        if (!ok || !pulse_ok) begin miscompares++; $display("FAIL hit_handshake: done %b single_pulse %b want 1 1", ok, pulse_ok); end
        vectors++;
        if (got !== exp_rdata) begin miscompares++; $display("FAIL hit_rdata: got %h want %h", got, exp_rdata); end
        vectors++;
        if (!log_matches()) begin miscompares++; $display("FAIL hit_traffic: got %0d bridge requests want %0d", req_log.size(), exp_log.size()); end
        vectors++;
        if (lat != 2) begin miscompares++; $display("FAIL hit_latency: got %0d edges want 2", lat); end
    endtask

    task automatic test_byte_write();
        logic [31:0] got; int lat; bit ok, pulse_ok;
        run_access(25'h0000010, 32'h11223344, 4'b0101, got, lat, ok, pulse_ok);
        vectors++;
        if (!ok || !pulse_ok) begin miscompares++; $display("FAIL wr_handshake: done %b single_pulse %b want 1 1", ok, pulse_ok); end
        vectors++;
        if (!log_matches()) begin miscompares++; $display("FAIL wr_traffic: got %0d bridge requests want %0d", req_log.size(), exp_log.size()); end
        vectors++;
        if (lat != 2) begin miscompares++; $display("FAIL wr_latency: got %0d edges want 2", lat); end
        run_access(25'h0000010, 32'h0, 4'h0, got, lat, ok, pulse_ok);
        vectors++;
        if (got !== exp_rdata) begin miscompares++; $display("FAIL wr_readback: got %h want %h", got, exp_rdata); end
    endtask

    task automatic test_dirty_evict();
        logic [31:0] got; int lat; bit ok, pulse_ok;
        bridge_lat = 1; bridge_hold = 2;
        run_access(25'h0000110, 32'h0, 4'h0, got, lat, ok, pulse_ok);
        vectors++;
        if (!ok || !pulse_ok) begin miscompares++; $display("FAIL evict_handshake: done %b single_pulse %b want 1 1", ok, pulse_ok); end
        vectors++;
        if (!log_matches()) begin miscompares++; $display("FAIL evict_traffic: got %0d bridge requests want %0d (WB then FILL)", req_log.size(), exp_log.size()); end
        vectors++;
        if (got !== exp_rdata) begin miscompares++; $display("FAIL evict_rdata: got %h want %h", got, exp_rdata); end
    endtask

    task automatic test_sticky_ready();
        logic [31:0] got; int lat; bit ok, pulse_ok;
        bridge_lat = 0; bridge_hold = 3;
        run_access(25'h0000228, 32'h0, 4'h0, got, lat, ok, pulse_ok);
        vectors++;
        if (!ok || !pulse_ok) begin miscompares++; $display("FAIL sticky_handshake: done %b single_pulse %b want 1 1", ok, pulse_ok); end
        vectors++;
        if (!log_matches()) begin miscompares++; $display("FAIL sticky_traffic: got %0d bridge requests want %0d", req_log.size(), exp_log.size()); end
        vectors++;
        if (got !== exp_rdata) begin miscompares++; $display("FAIL sticky_rdata: got %h want %h", got, exp_rdata); end
    endtask

    task automatic test_async_reset();
        logic [31:0] got; int lat, cyc; bit ok, pulse_ok, seen;
        bridge_lat = 6; bridge_hold = 0;
        req_log.delete();
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = 25'h0000750; cpu_wdata = '0; cpu_wstrb = 4'h0;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = mem_valid;
        end
        vectors++;
        if (!seen || mem_wstrb !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_fill_start: mem_valid %b mem_wstrb %b want 1 0", seen, mem_wstrb);
        end
        #2;
        rst = 1'b1;
        cpu_valid = 1'b0;
        #1;
        vectors++;
        if (mem_valid !== 1'b0 || cpu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_immediate: mem_valid %b cpu_ready %b want 0 0", mem_valid, cpu_ready);
        end
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bridge_lat = 1;
        run_access(25'h0000750, 32'h0, 4'h0, got, lat, ok, pulse_ok);
        vectors++;
        if (!ok || !pulse_ok) begin miscompares++; $display("FAIL areset_handshake: done %b single_pulse %b want 1 1", ok, pulse_ok); end
        vectors++;
        if (!log_matches()) begin miscompares++; $display("FAIL areset_traffic: got %0d bridge requests want %0d (miss, FILL only)", req_log.size(), exp_log.size()); end
        vectors++;
        if (got !== exp_rdata) begin miscompares++; $display("FAIL areset_rdata: got %h want %h", got, exp_rdata); end
    endtask

    task automatic test_random();
        logic [24:0] addr; logic [31:0] wd, got; logic [3:0] ws;
        int lat; bit ok, pulse_ok;
        for (int n = 0; n < 300; n++) begin
            bridge_lat  = $urandom_range(0, 3);
            bridge_hold = $urandom_range(0, 3);
            addr = {17'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom)};
            wd   = $urandom;
            ws   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            run_access(addr, wd, ws, got, lat, ok, pulse_ok);
            vectors++;
            if (!ok || !pulse_ok) begin
                miscompares++;
                $display("FAIL rand_handshake[%0d]: addr %h done %b single_pulse %b want 1 1", n, addr, ok, pulse_ok);
            end
            if (ws == 4'h0) begin
                vectors++;
                if (got !== exp_rdata) begin
                    miscompares++;
                    $display("FAIL rand_rdata[%0d]: addr %h got %h want %h", n, addr, got, exp_rdata);
                end
            end
            vectors++;
            if (!log_matches()) begin
                miscompares++;
                $display("FAIL rand_traffic[%0d]: addr %h got %0d bridge requests want %0d", n, addr, req_log.size(), exp_log.size());
            end
            if (exp_hit) begin
                vectors++;
                if (lat != 2) begin
                    miscompares++;
                    $display("FAIL rand_hit_latency[%0d]: addr %h got %0d edges want 2", n, addr, lat);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_byte_write();
        test_dirty_evict();
        test_sticky_ready();
        test_async_reset();
        test_random();
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ddr_line_cache.md
DDR_LINE_CACHE -- requirements
Module: ddr_line_cache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, meaning log2 of line count (16 lines of 128 bits); tag width = 21-INDEX_BITS.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-004 SHALL have port cpu_valid, input, 1, CPU request pending; held until cpu_ready.
REQ-005 SHALL have port cpu_addr, input, 25, byte address; [24:4+INDEX_BITS] tag, [3+INDEX_BITS:4] index, [3:2] word, [1:0] ignored.
REQ-006 SHALL have port cpu_wdata, input, 32, write data.
REQ-007 SHALL have port cpu_wstrb, input, 4, byte enables; 0 means read.
REQ-008 SHALL have port cpu_rdata, output, 32, read data, valid while cpu_ready=1.
REQ-009 SHALL have port cpu_ready, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port mem_addr, output, 21, 128-bit line address to DDR bridge.
REQ-011 SHALL have port mem_wdata, output, 128, line write data.
REQ-012 SHALL have port mem_wstrb, output, 1, 1 = line write, 0 = line read.
REQ-013 SHALL have port mem_valid, output, 1, bridge request.
REQ-014 SHALL have port mem_rdata, input, 128, line read data, valid while mem_ready=1.
REQ-015 SHALL have port mem_ready, input, 1, bridge completion; may stay high after a read until mem_valid drops.

Function
REQ-016 SHALL be direct-mapped, write-back, write-allocate; word w of a line occupies bits [32w+31:32w].
REQ-017 SHALL implement states IDLE, COMPARE, WB, WB_GAP, FILL, FILL_GAP, RESP.
REQ-018 IDLE: SHALL sample cpu_valid; if 1, register addr/wdata/wstrb and go to COMPARE; cpu_valid is ignored in all other states.
REQ-019 COMPARE: hit = valid[index] and tag match; hit -> RESP; miss with dirty[index] -> WB; miss clean -> FILL.
REQ-020 RESP: read hit SHALL drive cpu_rdata = selected word and cpu_ready=1 for exactly one cycle; write hit SHALL merge bytes where cpu_wstrb[i]=1, set dirty[index], pulse cpu_ready; then IDLE.
REQ-021 Hit latency SHALL be 2 cycles: cpu_valid sampled at edge N, cpu_ready high in the cycle after edge N+2.
REQ-022 WB: mem_valid=1, mem_wstrb=1, mem_addr={stored tag,index}, mem_wdata=line; on mem_ready=1, deassert mem_valid next cycle and go to WB_GAP.
REQ-023 FILL: mem_valid=1, mem_wstrb=0, mem_addr={request tag,index}; on mem_ready=1, write mem_rdata to line, set valid, clear dirty, deassert mem_valid, go to FILL_GAP.
REQ-024 WB_GAP/FILL_GAP: SHALL hold mem_valid=0 until mem_ready=0 observed, then go to FILL / COMPARE respectively (COMPARE then hits).
REQ-025 mem_addr, mem_wdata, mem_wstrb SHALL be stable whenever mem_valid=1.
REQ-026 mem_valid SHALL never assert while mem_ready=1 from the prior transaction.
REQ-027 Write miss SHALL fill first, then merge in RESP; the filled line ends dirty.
REQ-028 cpu_rdata SHALL be don't-care when cpu_ready=0; cpu_ready SHALL never be high two consecutive cycles.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, all valid and dirty bits 0, cpu_ready=0, mem_valid=0, mem_wstrb=0, mem_addr=0, cpu_rdata=0.
REQ-030 Data and tag arrays need not be reset.
REQ-031 Reset mid-transaction SHALL abandon it; the bridge is reset by the same event; no write-back occurs.

Verification
REQ-032 Cold read: after reset, read 0x0000010 -> FILL with mem_addr=0x000001, mem_wstrb=0; respond mem_rdata=128'h...DDDD_CCCC_BBBB_AAAA pattern -> cpu_rdata = word 0 of line; no WB.
REQ-033 Read hit: repeat read 0x0000014 -> no mem_valid; cpu_ready 2 cycles after sample; cpu_rdata = word 1.
REQ-034 Byte write hit: write 0x0000010, wdata 0x11223344, wstrb 4'b0101 -> only bytes 0,2 change; dirty[1]=1; readback matches.
REQ-035 Dirty eviction: then read 0x0000110 (index 1, tag 1) -> WB at mem_addr=0x000001 carrying merged line, WB_GAP waits for mem_ready low, then FILL at 0x000011.
REQ-036 Sticky bridge ready: hold mem_ready high 3 cycles after a FILL -> mem_valid stays 0 until mem_ready falls; no duplicate request.
REQ-037 Async reset during FILL -> mem_valid and cpu_ready 0 immediately; next read of same address misses.
